// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: command sequencer in front of a 16-bit combinational ALU.
// Accepts commands on a start/ready handshake.
// Runs single-cycle ALU ops, or a 16-step shift-add multiply built on the ALU's ADD.
// Registers the result and the Z/C/V flags.
// Optional multiply: define ALU_SEQ_CTRL_MUL_EN to build it.
// Without it, cmd=8 completes as an illegal command.
module alu_seq_ctrl #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       cmd,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             ready,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_co,
    input  logic             alu_overflow,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

    state_t           state_q, state_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_v_q, flag_v_d;
    // ALU drive is registered so it holds its last value while idle
    logic [2:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;

`ifdef ALU_SEQ_CTRL_MUL_EN
    localparam int CNT_W = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] count_q, count_d;
    // Full product is zero iff either operand is zero; the low half alone can't tell
    logic             mul_zero_q, mul_zero_d;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; illegal commands never leave IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!cmd[3]) state_d = S_EXEC;
`ifdef ALU_SEQ_CTRL_MUL_EN
                    else if (cmd == 4'd8) state_d = S_MUL;
`endif
                end
            end
            S_EXEC: state_d = S_IDLE;
`ifdef ALU_SEQ_CTRL_MUL_EN
            S_MUL:  if (count_q == LAST_CNT) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: only IDLE can take a command
    always_comb begin
        ready = (state_q == S_IDLE);
    end

    // Datapath next values: operand capture, ALU drive, completion
    always_comb begin
        done_d   = 1'b0;
        err_d    = 1'b0;
        result_d = result_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        flag_v_d = flag_v_q;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
`ifdef ALU_SEQ_CTRL_MUL_EN
        acc_d      = acc_q;
        m_d        = m_q;
        q_d        = q_q;
        count_d    = count_q;
        mul_zero_d = mul_zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!cmd[3]) begin
                        alu_op_d = cmd[2:0];
                        alu_a_d  = opa;
                        alu_b_d  = opb;
                    end
`ifdef ALU_SEQ_CTRL_MUL_EN
                    else if (cmd == 4'd8) begin
                        acc_d      = '0;
                        m_d        = opa;
                        q_d        = opb;
                        count_d    = '0;
                        mul_zero_d = (opa == '0) || (opb == '0);
                        // first partial-product add is presented in the first MUL cycle
                        alu_op_d   = 3'b000;
                        alu_a_d    = '0;
                        alu_b_d    = opb[0] ? opa : '0;
                    end
`endif
                    else begin
                        // illegal: complete at the accept edge, leave result/flags alone
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                result_d = alu_result;
                flag_z_d = alu_zero;
                flag_c_d = alu_co;
                flag_v_d = alu_overflow;
                done_d   = 1'b1;
            end
`ifdef ALU_SEQ_CTRL_MUL_EN
            S_MUL: begin
                acc_d   = alu_result;
                m_d     = m_q << 1;
                q_d     = q_q >> 1;
                count_d = count_q + CNT_W'(1);
                // pre-compute the next step's ALU operands from the shifted m/q
                alu_op_d = 3'b000;
                alu_a_d  = alu_result;
                alu_b_d  = q_q[1] ? (m_q << 1) : '0;
                if (count_q == LAST_CNT) begin
                    result_d = alu_result;
                    flag_z_d = mul_zero_q;
                    flag_c_d = 1'b0;
                    flag_v_d = 1'b0;
                    done_d   = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
        end else begin
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
            flag_v_q <= flag_v_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
        end
    end

`ifdef ALU_SEQ_CTRL_MUL_EN
    // Multiplier working registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q      <= '0;
            m_q        <= '0;
            q_q        <= '0;
            count_q    <= '0;
            mul_zero_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            m_q        <= m_d;
            q_q        <= q_d;
            count_q    <= count_d;
            mul_zero_q <= mul_zero_d;
        end
    end
`endif

    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
    assign flag_v = flag_v_q;
    assign alu_op = alu_op_q;
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a local 16-bit ALU model sits behind the controller.
// Vectors come from a table.
// Each accepted command pushes its expected completion to a scoreboard.
// A monitor pops and compares the scoreboard on every done.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  cmd = '0;
    logic [15:0] opa = '0, opb = '0;
    logic        ready, done, err, flag_z, flag_c, flag_v;
    logic [15:0] result;
    logic [2:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_res;
    logic        alu_co, alu_ov, alu_zero;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(16), .MUL_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cmd(cmd), .opa(opa), .opb(opb),
        .ready(ready), .done(done), .err(err), .result(result),
        .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_res), .alu_co(alu_co), .alu_overflow(alu_ov), .alu_zero(alu_zero)
    );

    // ALU model: 0 ADD, 1 SUB (co = borrow), 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 a<<1, 7 a>>1
    always_comb begin
        alu_res = '0;
        alu_co  = 1'b0;
        alu_ov  = 1'b0;
        case (alu_op)
            3'd0: begin
                {alu_co, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
                alu_ov = (alu_a[15] == alu_b[15]) && (alu_res[15] != alu_a[15]);
            end
            3'd1: begin
                {alu_co, alu_res} = {1'b0, alu_a} - {1'b0, alu_b};
                alu_ov = (alu_a[15] != alu_b[15]) && (alu_res[15] != alu_a[15]);
            end
            3'd2: alu_res = alu_a & alu_b;
            3'd3: alu_res = alu_a | alu_b;
            3'd4: alu_res = alu_a ^ alu_b;
            3'd5: alu_res = ~alu_a;
            3'd6: alu_res = alu_a << 1;
            default: alu_res = alu_a >> 1;
        endcase
    end
    assign alu_zero = (alu_res == 16'h0000);

    typedef struct {
        logic [3:0]  cmd;
        logic [15:0] a, b;
        logic        err;
        logic [15:0] res;
        logic        z, c, v;
        int          lat;
        logic        keep;   // result/flags must stay as the previous completion left them
    } vec_t;

    typedef struct {
        int          done_cyc;
        logic        err;
        logic [15:0] res;
        logic        z, c, v;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[$];
    int          n_tests = 0, n_fail = 0;
    int          cyc = 0;
    logic [15:0] m_res = '0;
    logic        m_z = 1'b0, m_c = 1'b0, m_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                                input logic e, input logic [15:0] r, input logic z,
                                input logic cf, input logic v, input int lat, input logic keep);
        vec_t t;
        t.cmd = c; t.a = a; t.b = b; t.err = e; t.res = r;
        t.z = z; t.c = cf; t.v = v; t.lat = lat; t.keep = keep;
        return t;
    endfunction

    function automatic vec_t illegal(input logic [3:0] c);
        return mk(c, 16'h0005, 16'h0005, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    endfunction

    task automatic push_exp(input vec_t v, input int acc_cyc);
        exp_t e;
        if (!v.keep) begin
            m_res = v.res; m_z = v.z; m_c = v.c; m_v = v.v;
        end
        e.done_cyc = acc_cyc + v.lat;
        e.err = v.err; e.res = m_res; e.z = m_z; e.c = m_c; e.v = m_v;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge with start low
    task automatic issue(input vec_t v);
        int t = 0;
        while (!ready && t < 100) begin @(negedge clk); t++; end
        check("issue_ready_timeout", {31'b0, ready}, 32'd1);
        start = 1'b1; cmd = v.cmd; opa = v.a; opb = v.b;
        push_exp(v, cyc + 1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (sb.size() != 0 && t < 60) begin @(negedge clk); t++; end
        check("drain_timeout", sb.size(), 32'd0);
    endtask

    // Scoreboard monitor, sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {31'b0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc, e.done_cyc);
                check("err", {31'b0, err}, {31'b0, e.err});
                check("result", {16'b0, result}, {16'b0, e.res});
                check("flags_zcv", {29'b0, flag_z, flag_c, flag_v}, {29'b0, e.z, e.c, e.v});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, {31'b0, ready}, 32'd1);
        check({tag, "_done_err"}, {30'b0, done, err}, 32'd0);
        check({tag, "_result"}, {16'b0, result}, 32'd0);
        check({tag, "_flags"}, {29'b0, flag_z, flag_c, flag_v}, 32'd0);
        check({tag, "_alu_drive"}, {alu_op, alu_a[12:0], alu_b}, 32'd0);
    endtask

    initial begin
        // table: cmd, a, b, err, result, z, c, v, latency, keep
        vecs.push_back(mk(4'd0, 16'd100,  16'd120,  1'b0, 16'd220,  1'b0, 1'b0, 1'b0, 1, 1'b0));
        vecs.push_back(mk(4'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1, 1'b0));
        vecs.push_back(mk(4'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1, 1'b0));
        vecs.push_back(illegal(4'd12));
        vecs.push_back(mk(4'd1, 16'd5,    16'd7,    1'b0, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1, 1'b0));
        vecs.push_back(mk(4'd2, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1, 1'b0));
        vecs.push_back(mk(4'd3, 16'h1200, 16'h0034, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1, 1'b0));
`ifdef ALU_SEQ_CTRL_MUL_EN
        vecs.push_back(mk(4'd8, 16'd300,  16'd200,  1'b0, 16'hEA60, 1'b0, 1'b0, 1'b0, 16, 1'b0));
        vecs.push_back(mk(4'd8, 16'd300,  16'd300,  1'b0, 16'h5F90, 1'b0, 1'b0, 1'b0, 16, 1'b0));
        vecs.push_back(mk(4'd8, 16'd0,    16'd1234, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16, 1'b0));
        vecs.push_back(mk(4'd8, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 16, 1'b0));
`else
        vecs.push_back(illegal(4'd8));
`endif
        vecs.push_back(illegal(4'd15));
        vecs.push_back(mk(4'd0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1, 1'b0));
        vecs.push_back(mk(4'd4, 16'hFFFF, 16'h00FF, 1'b0, 16'hFF00, 1'b0, 1'b0, 1'b0, 1, 1'b0));

        // reset state
        repeat (2) @(negedge clk);
        check_reset_vals("reset_init");
        reset_n = 1'b1;
        @(negedge clk);

        // table-driven vectors
        foreach (vecs[i]) begin
            issue(vecs[i]);
            if (vecs[i].lat == 0) check("illegal_ready_held", {31'b0, ready}, 32'd1);
            wait_idle();
        end

        // ready low while busy; a start pulse during the busy window is ignored
`ifdef ALU_SEQ_CTRL_MUL_EN
        issue(mk(4'd8, 16'd7, 16'd9, 1'b0, 16'd63, 1'b0, 1'b0, 1'b0, 16, 1'b0));
        for (int i = 0; i < 16; i++) begin
            check("mul_ready_low", {31'b0, ready}, 32'd0);
            if (i == 3) begin start = 1'b1; cmd = 4'd0; opa = 16'd9; opb = 16'd9; end
            if (i == 4) start = 1'b0;
            @(negedge clk);
        end
`else
        issue(mk(4'd0, 16'd7, 16'd9, 1'b0, 16'd16, 1'b0, 1'b0, 1'b0, 1, 1'b0));
        check("exec_ready_low", {31'b0, ready}, 32'd0);
        start = 1'b1; cmd = 4'd0; opa = 16'd9; opb = 16'd9;
        @(negedge clk);
        start = 1'b0;
`endif
        wait_idle();
        check("ready_after_busy", {31'b0, ready}, 32'd1);

        // back-to-back: start held high across ADD(1,2) then ADD(3,4)
        start = 1'b1; cmd = 4'd0; opa = 16'd1; opb = 16'd2;
        push_exp(mk(4'd0, 16'd1, 16'd2, 1'b0, 16'd3, 1'b0, 1'b0, 1'b0, 1, 1'b0), cyc + 1);
        @(posedge clk);
        @(negedge clk);
        opa = 16'd3; opb = 16'd4;
        @(negedge clk);
        check("b2b_done_ready", {30'b0, done, ready}, 32'd3);
        push_exp(mk(4'd0, 16'd3, 16'd4, 1'b0, 16'd7, 1'b0, 1'b0, 1'b0, 1, 1'b0), cyc + 1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // reset in the middle of a command: no done for it, outputs back to reset values
`ifdef ALU_SEQ_CTRL_MUL_EN
        issue(mk(4'd8, 16'd300, 16'd200, 1'b0, 16'hEA60, 1'b0, 1'b0, 1'b0, 16, 1'b0));
        repeat (6) @(negedge clk);
`else
        issue(mk(4'd0, 16'd300, 16'd200, 1'b0, 16'd500, 1'b0, 1'b0, 1'b0, 1, 1'b0));
`endif
        reset_n = 1'b0;
        #1;
        check_reset_vals("reset_mid");
        sb.delete();
        m_res = '0; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        issue(mk(4'd0, 16'd5, 16'd6, 1'b0, 16'd11, 1'b0, 1'b0, 1'b0, 1, 1'b0));
        wait_idle();
        repeat (20) @(negedge clk);
        check("final_idle_ready", {31'b0, ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
